apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester that turns single-beat commands from a local valid/ready interface into APB SETUP/ACCESS transfers.
- Returns one response per command (read data, error, timeout) back to the local side.
- Sits between a bus-initiating agent (test sequencer, DMA, CPU bridge) and APB completers such as apb_slave, which uses the same 10-bit address and 32-bit data widths.

Parameters:
- ADDR_WIDTH, 10, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for pready before abort; 0 disables timeout.

Ports:
- pclk  in  1  APB clock, rising-edge.
- presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB completer ready.
- pslverr  in  1  APB completer error.

Behaviour:
- Reset is asserted by presetn low, asynchronously. All APB outputs are registered and go to 0 immediately: psel, penable, pwrite, paddr, pwdata. rsp_valid, rsp_rdata, rsp_err and rsp_timeout also go to 0. The state goes to IDLE.
- cmd_ready = (state==IDLE) & presetn. It is combinational from the state register only, with no dependency on cmd_valid.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel=0, penable=0.
  - On cmd_valid & cmd_ready: latch cmd_write/addr/wdata into pwrite/paddr/pwdata, set psel=1 and go to SETUP.
  - For reads, pwdata=0.
- SETUP (exactly one cycle): psel=1, penable=0. The next state is always ACCESS, with penable=1.
- ACCESS: psel=1, penable=1. paddr, pwrite and pwdata are held stable for the whole transfer.
  - pready=1 at posedge:
    - Set rsp_valid=1 for the next cycle.
    - rsp_rdata = prdata for reads, 0 for writes.
    - rsp_err = pslverr, rsp_timeout = 0.
    - Clear psel/penable and go to IDLE.
  - pready=0: the wait counter increments.
  - Timeout (TIMEOUT_CYCLES>0): when the wait counter reaches TIMEOUT_CYCLES with pready still 0:
    - Abort by clearing psel/penable and going to IDLE.
    - Response is rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The wait counter clears on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1).
- pslverr and prdata are ignored except on the completing ACCESS cycle (pready=1).
- Response signals:
  - rsp_valid is high for exactly one cycle per accepted command. It has no backpressure; the consumer must take it.
  - rsp_rdata, rsp_err and rsp_timeout hold their value until the next response.
- Latency, zero-wait transfer: accept at edge N, SETUP in cycle N..N+1, ACCESS in N+1..N+2, rsp_valid high in N+2..N+3. The same cycle is back in IDLE with cmd_ready=1.
- Throughput: minimum 3 cycles per command; IDLE is always revisited between transfers.
- cmd_valid deasserting while not ready has no effect. Commands are never dropped or duplicated.
- Reset mid-transfer: the transfer is abandoned with no response issued, and outputs follow the reset values.

Test Plan:
- Write, zero wait:
  - Stimulus: cmd write addr=0x004 data=0xDEADBEEF, pready tied 1.
  - Required: SETUP then ACCESS with paddr=0x004, pwrite=1, pwdata=0xDEADBEEF.
  - Required: rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read, 2 wait states:
  - Stimulus: read addr=0x3FF, pready low 2 ACCESS cycles then high with prdata=0x12345678.
  - Required: penable high 3 cycles, rsp_rdata=0x12345678, rsp_valid 4 cycles after accept.
- Slave error:
  - Stimulus: write addr=0x010, pready=1 with pslverr=1.
  - Required: rsp_err=1, rsp_timeout=0.
  - Required: pslverr pulses during SETUP or wait cycles have no effect.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, pready held 0.
  - Required: psel/penable drop after 16 ACCESS cycles.
  - Required: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0; cmd_ready=1 next cycle.
- Back-to-back:
  - Stimulus: cmd_valid held with 4 commands against apb_slave (write 0x0A5, 0xCAFEF00D; read 0x0A5; ...).
  - Required: each accepted every 3 cycles, read returns 0xCAFEF00D, exactly 4 rsp_valid pulses.
- Reset mid-ACCESS:
  - Stimulus: presetn low during wait state.
  - Required: psel/penable/paddr/pwdata go 0 asynchronously, no rsp_valid.
  - Required: after release, cmd_ready=1 and the next command completes normally.

Source files
------------

// File: rtl/apb_master.sv
// Purpose    : APB requester; turns single-beat local commands into APB SETUP/ACCESS transfers.
// Latency    : accept at edge N, SETUP N..N+1, ACCESS from N+1, rsp_valid 1 cycle after pready (min 3 cycles/cmd).
// Backpressure: cmd_ready only in IDLE; responses are a one-cycle strobe with no backpressure.
//
// Ports:
//   pclk, presetn                    clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata local command channel (valid/ready)
//   rsp_valid/rdata/err/timeout      local response strobe; data/flags hold until next response
//   psel/penable/pwrite/paddr/pwdata APB request outputs (all registered)
//   prdata/pready/pslverr            APB completer inputs
module apb_master #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    // A zero-width counter is illegal, so keep one bit when the timeout is disabled.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The counter holds the number of ACCESS cycles already spent waiting, so the
    // abort fires in the ACCESS cycle where it would step up to TIMEOUT_CYCLES.
    localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           wait_cnt, wait_cnt_nxt;
    logic                    psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt;
    logic                    rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;
    logic                    timeout_hit;

    assign cmd_ready   = (state == IDLE) && presetn;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        psel_nxt        = psel;
        penable_nxt     = penable;
        pwrite_nxt      = pwrite;
        paddr_nxt       = paddr;
        pwdata_nxt      = pwdata;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        rsp_timeout_nxt = rsp_timeout;

        case (state)
            IDLE: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    pwrite_nxt   = cmd_write;
                    paddr_nxt    = cmd_addr;
                    pwdata_nxt   = cmd_write ? cmd_wdata : '0;
                    psel_nxt     = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = pwrite ? '0 : prdata;
                    rsp_err_nxt     = pslverr;
                    rsp_timeout_nxt = 1'b0;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    state_nxt       = IDLE;
                end else if (timeout_hit) begin
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = '0;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    state_nxt       = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            wait_cnt    <= wait_cnt_nxt;
            psel        <= psel_nxt;
            penable     <= penable_nxt;
            pwrite      <= pwrite_nxt;
            paddr       <= paddr_nxt;
            pwdata      <= pwdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Purpose    : self-checking bench for apb_master with a transaction-level reference model.
// Latency    : n/a (bench).
// Backpressure: n/a (bench); the bench completer inserts a programmable number of wait states.
module tb_apb_master;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          pclk    = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    always #5 pclk = ~pclk;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // ---------------- bench completer: memory with programmable wait states ----------------
    int            ws         = 0;     // ACCESS cycles with pready low before completing
    bit            err_flag   = 1'b0;  // pslverr on the completing cycle
    bit            noise_flag = 1'b0;  // pslverr on every non-completing cycle
    int            acc_wait   = 0;
    int            cyc        = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (psel && penable && !pready) acc_wait <= acc_wait + 1;
        else                            acc_wait <= 0;
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end

    assign pready  = (acc_wait >= ws);
    assign prdata  = pready ? mem[paddr] : 32'hBAD0BAD0;
    assign pslverr = (err_flag && pready) || (noise_flag && !pready);

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: one outstanding transfer, described by how many cycles have
    // elapsed since it was accepted (0 = SETUP, >=1 = ACCESS cycle number).
    bit            m_busy = 1'b0;
    int            m_k    = 0;
    bit            m_w    = 1'b0;
    logic [AW-1:0] m_a    = '0;
    logic [DW-1:0] m_d    = '0;
    bit            m_rv   = 1'b0;
    logic [DW-1:0] m_rd   = '0;
    bit            m_re   = 1'b0;
    bit            m_rt   = 1'b0;

    initial begin
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                m_busy = 1'b0; m_k = 0; m_rv = 1'b0; m_rd = '0; m_re = 1'b0; m_rt = 1'b0;
                chk("rst_psel", psel, 0);
                chk("rst_penable", penable, 0);
                chk("rst_pwrite", pwrite, 0);
                chk("rst_paddr", paddr, 0);
                chk("rst_pwdata", pwdata, 0);
                chk("rst_cmd_ready", cmd_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_rsp_err", rsp_err, 0);
                chk("rst_rsp_timeout", rsp_timeout, 0);
            end else begin
                chk("m_cmd_ready", cmd_ready, !m_busy);
                chk("m_psel", psel, m_busy);
                chk("m_penable", penable, m_busy && (m_k >= 1));
                if (m_busy) begin
                    chk("m_paddr", paddr, m_a);
                    chk("m_pwrite", pwrite, m_w);
                    chk("m_pwdata", pwdata, m_w ? m_d : 32'h0);
                end
                chk("m_rsp_valid", rsp_valid, m_rv);
                chk("m_rsp_rdata", rsp_rdata, m_rd);
                chk("m_rsp_err", rsp_err, m_re);
                chk("m_rsp_timeout", rsp_timeout, m_rt);
                // predict the effect of the coming rising edge
                m_rv = 1'b0;
                if (m_busy) begin
                    if (m_k >= 1 && pready) begin
                        m_rv = 1'b1; m_rd = m_w ? 32'h0 : prdata;
                        m_re = pslverr; m_rt = 1'b0; m_busy = 1'b0;
                    end else if (m_k >= 1 && TO > 0 && m_k == TO) begin
                        m_rv = 1'b1; m_rd = 32'h0; m_re = 1'b1; m_rt = 1'b1; m_busy = 1'b0;
                    end else begin
                        m_k++;
                    end
                end else if (cmd_valid) begin
                    m_busy = 1'b1; m_k = 0; m_w = cmd_write; m_a = cmd_addr; m_d = cmd_wdata;
                end
            end
        end
    end

    logic [DW-1:0] rsp_log[$];
    int            acc_log[$];

    initial begin
        forever begin
            @(negedge pclk);
            if (rsp_valid) rsp_log.push_back(rsp_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    bit            s_psel, s_pen, s_write;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Present a command and wait for the handshake; returns 1 time unit after the accepting edge.
    task automatic send_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!ok && n < 50) begin
            @(negedge pclk);
            n++;
            if (cmd_ready) begin
                ok = 1'b1;
                acc_log.push_back(cyc);
            end
        end
        if (!ok) chk("accept_wait_expired", 0, 1);
        @(posedge pclk);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    // Called right after send_cmd: lat = edges from accept to the edge raising rsp_valid,
    // pen = cycles with penable high; the first cycle (SETUP) is snapshotted.
    task automatic wait_rsp(output int lat, output int pen);
        int n;
        bit got;
        n = 0; got = 1'b0; pen = 0;
        while (!got && n < 40) begin
            @(negedge pclk);
            n++;
            if (penable) pen++;
            if (n == 1) begin
                s_psel = psel; s_pen = penable; s_write = pwrite; s_addr = paddr; s_wdata = pwdata;
            end
            if (rsp_valid) got = 1'b1;
        end
        if (!got) chk("rsp_wait_expired", 0, 1);
        lat = n - 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    int lat, pen, nrsp;

    initial begin
        repeat (3) @(negedge pclk);
        chk("reset_cmd_ready", cmd_ready, 0);
        @(posedge pclk); #2 presetn = 1'b1;
        @(negedge pclk);
        chk("post_reset_cmd_ready", cmd_ready, 1);
        step();

        // write, zero wait
        ws = 0;
        send_cmd(1'b1, 10'h004, 32'hDEADBEEF, 1'b0);
        wait_rsp(lat, pen);
        chk("wr_setup_psel", s_psel, 1);
        chk("wr_setup_penable", s_pen, 0);
        chk("wr_paddr", s_addr, 32'h004);
        chk("wr_pwrite", s_write, 1);
        chk("wr_pwdata", s_wdata, 32'hDEADBEEF);
        chk("wr_latency", lat, 2);
        chk("wr_penable_cycles", pen, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_cmd_ready_at_rsp", cmd_ready, 1);
        step();

        // preload 0x3FF, then read it with two wait states
        send_cmd(1'b1, 10'h3FF, 32'h12345678, 1'b0);
        wait_rsp(lat, pen);
        step();
        ws = 2;
        send_cmd(1'b0, 10'h3FF, 32'hFFFFFFFF, 1'b0);
        wait_rsp(lat, pen);
        chk("rd_pwdata_zero", s_wdata, 0);
        chk("rd_pwrite", s_write, 0);
        chk("rd_penable_cycles", pen, 3);
        chk("rd_latency", lat, 4);
        chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
        step();

        // pslverr noise during SETUP and wait cycles is ignored
        ws = 2; noise_flag = 1'b1;
        send_cmd(1'b1, 10'h010, 32'h00000011, 1'b0);
        wait_rsp(lat, pen);
        chk("noise_rsp_err", rsp_err, 0);
        step();
        // slave error on the completing cycle
        ws = 0; noise_flag = 1'b0; err_flag = 1'b1;
        send_cmd(1'b1, 10'h010, 32'h00000022, 1'b0);
        wait_rsp(lat, pen);
        chk("slverr_rsp_err", rsp_err, 1);
        chk("slverr_rsp_timeout", rsp_timeout, 0);
        step();
        err_flag = 1'b0;

        // timeout
        ws = 1000;
        send_cmd(1'b0, 10'h020, 32'h0, 1'b0);
        wait_rsp(lat, pen);
        chk("to_penable_cycles", pen, 16);
        chk("to_latency", lat, 17);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_psel_dropped", psel, 0);
        chk("to_cmd_ready", cmd_ready, 1);
        step();

        // back-to-back with cmd_valid held
        ws = 0;
        rsp_log.delete();
        acc_log.delete();
        send_cmd(1'b1, 10'h0A5, 32'hCAFEF00D, 1'b1);
        send_cmd(1'b0, 10'h0A5, 32'h0,        1'b1);
        send_cmd(1'b1, 10'h15A, 32'h0BADF00D, 1'b1);
        send_cmd(1'b0, 10'h15A, 32'h0,        1'b0);
        repeat (6) @(negedge pclk);
        chk("b2b_rsp_count", rsp_log.size(), 4);
        if (rsp_log.size() == 4) begin
            chk("b2b_wr0_rdata", rsp_log[0], 0);
            chk("b2b_rd0_rdata", rsp_log[1], 32'hCAFEF00D);
            chk("b2b_rd1_rdata", rsp_log[3], 32'h0BADF00D);
        end
        chk("b2b_accept_count", acc_log.size(), 4);
        for (int i = 1; i < acc_log.size(); i++) chk("b2b_accept_spacing", acc_log[i] - acc_log[i-1], 3);
        step();

        // reset during an ACCESS wait state
        ws = 1000;
        send_cmd(1'b1, 10'h055, 32'h55AA55AA, 1'b0);
        repeat (3) @(negedge pclk);
        chk("pre_reset_penable", penable, 1);
        nrsp = rsp_log.size();
        @(posedge pclk); #2 presetn = 1'b0;
        #1;
        chk("async_rst_psel", psel, 0);
        chk("async_rst_penable", penable, 0);
        chk("async_rst_paddr", paddr, 0);
        chk("async_rst_pwdata", pwdata, 0);
        repeat (2) @(posedge pclk);
        #2 presetn = 1'b1;
        ws = 0;
        @(negedge pclk);
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rst_no_rsp", rsp_log.size(), nrsp);
        step();
        send_cmd(1'b0, 10'h0A5, 32'h0, 1'b0);
        wait_rsp(lat, pen);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_rdata", rsp_rdata, 32'hCAFEF00D);
        step();
        repeat (2) @(negedge pclk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
